// File: rtl/issrr_pkg.sv
// Shared widths and helpers for the issue-queue to register-read pipeline.
package issrr_pkg;

    localparam int LANES_MAX = 8;
    localparam int CKPTS_MAX = 16;
    localparam int BM_MAX    = LANES_MAX * CKPTS_MAX;
    localparam int CNT_W     = $clog2(LANES_MAX + 1);
    localparam int KILL_W    = $clog2(4 * LANES_MAX + 1);
    localparam int PERF_W    = 32;

    function automatic logic [CNT_W-1:0] popcount_lanes(
        input logic [LANES_MAX-1:0] v
    );
        logic [CNT_W-1:0] n;
        logic [LANES_MAX-1:0] t;
        n = '0;
        for (int i = 0; i < LANES_MAX; i++) begin
            t = v >> i;
            n = n + CNT_W'(t[0]);
        end
        return n;
    endfunction

    // Masks arrive packed lane-major, ckpts bits per lane.
    function automatic logic [LANES_MAX-1:0] kill_vec(
        input logic [BM_MAX-1:0] bmask,
        input int unsigned       id,
        input logic              en,
        input int unsigned       lanes,
        input int unsigned       ckpts
    );
        logic [LANES_MAX-1:0] k;
        logic [BM_MAX-1:0] t;
        k = '0;
        for (int unsigned i = 0; i < LANES_MAX; i++) begin
            t = bmask >> (i * ckpts + id);
            if (en && i < lanes) k[i] = t[0];
        end
        return k;
    endfunction

endpackage

// File: rtl/issrr_stage.sv
// One lane-parallel pipeline stage: valid/payload/mask registers with
// hold, squash and checkpoint-clear handling.
module issrr_stage
    import issrr_pkg::*;
#(
    parameter int NUM_LANES = 6,
    parameter int PKT_W     = 128,
    parameter int CKPTS     = 8,
    parameter int CKPT_LOG  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       mispredict,
    input  logic [CKPT_LOG-1:0]        mispredictId,
    input  logic                       resolve,
    input  logic [CKPT_LOG-1:0]        resolveId,
    input  logic [NUM_LANES-1:0]       validIn,
    input  logic [NUM_LANES*PKT_W-1:0] pktIn,
    input  logic [NUM_LANES*CKPTS-1:0] maskIn,
    output logic [NUM_LANES-1:0]       validOut,
    output logic [NUM_LANES*PKT_W-1:0] pktOut,
    output logic [NUM_LANES*CKPTS-1:0] maskOut,
    output logic [NUM_LANES-1:0]       validNext,
    output logic [CNT_W-1:0]           killCnt
);

    logic [NUM_LANES-1:0]       srcValid;
    logic [NUM_LANES-1:0]       killed;
    logic [NUM_LANES-1:0]       load;
    logic [NUM_LANES*CKPTS-1:0] srcMask;
    logic [NUM_LANES*CKPTS-1:0] clrAll;
    logic [NUM_LANES*CKPTS-1:0] maskClr;
    logic [NUM_LANES*CKPTS-1:0] maskNext;
    logic [NUM_LANES*CKPTS-1:0] laneMask;
    logic [NUM_LANES*PKT_W-1:0] lanePkt;
    logic [BM_MAX-1:0]          maskWide;
    logic [LANES_MAX-1:0]       killWide;
    logic [LANES_MAX-1:0]       cntWide;
    logic [CKPTS-1:0]           clrOne;

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        assign laneMask[g*CKPTS +: CKPTS] = {CKPTS{load[g]}};
        assign lanePkt[g*PKT_W +: PKT_W]  = {PKT_W{load[g]}};
    end

    always_comb begin
        srcValid = stall ? validOut : validIn;
        srcMask  = stall ? maskOut : maskIn;
        maskWide = '0;
        maskWide[NUM_LANES*CKPTS-1:0] = srcMask;
        killWide = kill_vec(maskWide, int'(mispredictId), mispredict,
                            NUM_LANES, CKPTS);
        killed   = srcValid & killWide[NUM_LANES-1:0];
        clrOne   = resolve ? (CKPTS'(1) << resolveId) : '0;
        clrAll   = {NUM_LANES{clrOne}};
        maskClr  = srcMask & ~clrAll;
        load     = stall ? '0 : validIn;
        // Idle lanes keep stale payload; only valid lanes toggle flops.
        maskNext = stall ? maskClr
                         : (maskClr & laneMask) | (maskOut & ~laneMask);
        validNext = flush ? '0 : (srcValid & ~killed);
        cntWide = '0;
        cntWide[NUM_LANES-1:0] = flush ? validOut : killed;
        killCnt = popcount_lanes(cntWide);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validOut <= '0;
            pktOut   <= '0;
            maskOut  <= '0;
        end else begin
            validOut <= validNext;
            pktOut   <= (pktIn & lanePkt) | (pktOut & ~lanePkt);
            maskOut  <= maskNext;
        end
    end

endmodule

// File: rtl/issueq_regread_pipe.sv
// Issue-grant to register-read pipeline, DEPTH stages of NUM_LANES slots.
// Optional perf counters enabled with `define ISSRR_PERF_CNT_EN.
module issueq_regread_pipe
    import issrr_pkg::*;
#(
    parameter  int NUM_LANES = 6,
    parameter  int PKT_W     = 128,
    parameter  int DEPTH     = 1,
    parameter  int CKPTS     = 8,
    parameter  int CKPT_LOG  = 3,
    localparam int OCC_W     = $clog2(DEPTH * NUM_LANES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       mispredict_i,
    input  logic [CKPT_LOG-1:0]        mispredict_id_i,
    input  logic                       resolve_i,
    input  logic [CKPT_LOG-1:0]        resolve_id_i,
    input  logic [NUM_LANES-1:0]       valid_i,
    input  logic [NUM_LANES*PKT_W-1:0] packet_i,
    input  logic [NUM_LANES*CKPTS-1:0] bmask_i,
    output logic [NUM_LANES-1:0]       valid_o,
    output logic [NUM_LANES*PKT_W-1:0] packet_o,
    output logic [NUM_LANES*CKPTS-1:0] bmask_o,
    output logic [OCC_W-1:0]           occ_o
`ifdef ISSRR_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]          perf_issued_o,
    output logic [PERF_W-1:0]          perf_squashed_o
`endif
);

    logic [NUM_LANES-1:0]       vChain [DEPTH+1];
    logic [NUM_LANES*PKT_W-1:0] pChain [DEPTH+1];
    logic [NUM_LANES*CKPTS-1:0] mChain [DEPTH+1];
    logic [OCC_W-1:0]           occAcc [DEPTH+1];
    logic [KILL_W-1:0]          killAcc [DEPTH+1];

    assign vChain[0]  = valid_i;
    assign pChain[0]  = packet_i;
    assign mChain[0]  = bmask_i;
    assign occAcc[0]  = '0;
    assign killAcc[0] = '0;

    for (genvar s = 0; s < DEPTH; s++) begin : gStage
        logic [NUM_LANES-1:0] vNext;
        logic [CNT_W-1:0]     kCnt;

        issrr_stage #(
            .NUM_LANES (NUM_LANES),
            .PKT_W     (PKT_W),
            .CKPTS     (CKPTS),
            .CKPT_LOG  (CKPT_LOG)
        ) uStage (
            .clk          (clk),
            .reset        (reset),
            .stall        (stall_i),
            .flush        (flush_i),
            .mispredict   (mispredict_i),
            .mispredictId (mispredict_id_i),
            .resolve      (resolve_i),
            .resolveId    (resolve_id_i),
            .validIn      (vChain[s]),
            .pktIn        (pChain[s]),
            .maskIn       (mChain[s]),
            .validOut     (vChain[s+1]),
            .pktOut       (pChain[s+1]),
            .maskOut      (mChain[s+1]),
            .validNext    (vNext),
            .killCnt      (kCnt)
        );

        assign occAcc[s+1] = occAcc[s]
            + OCC_W'(popcount_lanes(LANES_MAX'(vNext)));
        assign killAcc[s+1] = killAcc[s] + KILL_W'(kCnt);
    end

    assign valid_o  = vChain[DEPTH];
    assign packet_o = pChain[DEPTH];
    assign bmask_o  = mChain[DEPTH];

    always_ff @(posedge clk) begin
        if (reset) occ_o <= '0;
        else       occ_o <= occAcc[DEPTH];
    end

`ifdef ISSRR_PERF_CNT_EN
    logic [PERF_W:0] issSum;
    logic [PERF_W:0] sqSum;

    always_comb begin
        issSum = {1'b0, perf_issued_o}
               + (PERF_W+1)'(popcount_lanes(LANES_MAX'(valid_o)));
        sqSum  = {1'b0, perf_squashed_o} + (PERF_W+1)'(killAcc[DEPTH]);
    end

    // Saturate instead of wrapping so long runs stay monotonic.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_o   <= '0;
            perf_squashed_o <= '0;
        end else begin
            if (!stall_i)
                perf_issued_o <= issSum[PERF_W] ? '1 : issSum[PERF_W-1:0];
            perf_squashed_o <= sqSum[PERF_W] ? '1 : sqSum[PERF_W-1:0];
        end
    end
`else
    logic [KILL_W-1:0] unusedKill;
    assign unusedKill = killAcc[DEPTH];
`endif

endmodule

// File: doc/issueq_regread_pipe.md
Name: issueq_regread_pipe

Overview:
- Parametrised pipeline between the issue-queue select/grant logic and register read. Generalises the fixed 6-lane, 1-stage issue/regread latch.
- Configurable lane count, packet width and stage depth.
- Adds a global stall, a full flush, and per-checkpoint branch-mask squash/clear for packets in flight.
- Sits directly after issue grant; its outputs drive the physical register file read ports.

Parameters:
- NUM_LANES, 6, issue width (number of granted lanes), 1..8
- PKT_W, 128, granted payload width per lane, excluding branch mask
- DEPTH, 1, number of register stages issue->regread, 1..4
- CKPTS, 8, number of branch checkpoints = branch-mask width per lane
- CKPT_LOG, 3, clog2(CKPTS)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  regread back-pressure; all stages hold
- flush_i  in  1  full pipeline flush (exception/recovery)
- mispredict_i  in  1  branch with checkpoint mispredict_id_i mispredicted
- mispredict_id_i  in  CKPT_LOG  checkpoint id being squashed
- resolve_i  in  1  branch resolved correctly
- resolve_id_i  in  CKPT_LOG  checkpoint id being released
- valid_i  in  NUM_LANES  per-lane granted valid
- packet_i  in  NUM_LANES*PKT_W  lane payloads; lane k at [k*PKT_W +: PKT_W]
- bmask_i  in  NUM_LANES*CKPTS  per-lane branch dependency masks
- valid_o  out  NUM_LANES  final-stage valids
- packet_o  out  NUM_LANES*PKT_W  final-stage payloads
- bmask_o  out  NUM_LANES*CKPTS  final-stage masks, with resolved bits cleared
- occ_o  out  clog2(DEPTH*NUM_LANES+1)  count of valid lane-slots held across all stages

Behaviour:
- Reset:
  - All stage valids, packets and masks clear to 0.
  - valid_o, packet_o, bmask_o and occ_o read 0 the cycle after reset is sampled.
  - Reset mid-stream discards all in-flight packets.
- Latency: a lane valid at the input with no stall appears at the output exactly DEPTH cycles later, in the same lane. Lanes are never reordered or compacted.
- Advance (stall_i=0):
  - stage0 captures the input and stage s captures stage s-1.
  - Valid bits always load.
  - Packet and mask registers load only when the incoming valid is 1; otherwise they hold stale contents (power saving). Verification must ignore the payload whenever valid=0.
- Stall (stall_i=1):
  - Every stage holds its payload. Inputs are ignored; the issue queue must not grant while stalled.
  - Kill and clear rules still apply to held entries.
- Squash: when mispredict_i=1, any slot in any stage, or any incoming lane, whose mask bit [mispredict_id_i] is 1 has its valid forced to 0 that cycle.
- Clear: when resolve_i=1, bit [resolve_id_i] is cleared in every held mask and in incoming masks as they are captured.
- Simultaneous events:
  - mispredict and resolve on the same id: squash wins, and the bit is also cleared.
  - Different ids: both apply.
- Flush (flush_i=1): all stage valids clear next cycle, including input capture. Flush has priority over stall and mispredict.
- occ_o is the registered popcount of all stage valid bits after the kill/flush rules are applied. It is 0 after flush.
- DEPTH=1, with no stall/flush/mispredict activity, is cycle-equivalent to the legacy latch.

Optional Feature:
- Macro: ISSRR_PERF_CNT_EN.
- When defined:
  - Adds 32-bit outputs perf_issued_o and perf_squashed_o.
  - perf_issued_o increments by popcount(valid_o) each non-stalled cycle.
  - perf_squashed_o increments by the number of valid slots killed by mispredict or flush that cycle.
  - Both counters saturate at 2^32-1 and reset to 0.
- When undefined: neither port nor counter exists, and area is unchanged.

Decomposition:
- Package issrr_pkg holds:
  - localparams for lane-slice widths and the occupancy width;
  - a function popcount_lanes;
  - a function kill_vec(bmask, id, en), which returns per-lane kill bits.
- Sub-module issrr_stage: one NUM_LANES-wide stage containing the valid/payload/mask registers plus the kill/clear/hold logic. The top module generates DEPTH instances of it in a chain.

Test Plan:
- DEPTH=2, lanes 0 and 3 valid with packets 0xA5 and 0x5A, no stall → valid_o=4'b1001, with those payloads exactly 2 cycles later; other lanes' payloads unchanged.
- Stall asserted for 3 cycles with stage1 full → outputs frozen for 3 cycles, then advance on release; no packet loss or duplication; occ_o stays constant during the stall.
- Lane 2 in stage0 with bmask=8'h04; mispredict_id=2 → lane 2 never reaches the output. Another lane with bmask=8'h08 survives; occ_o drops by 1.
- resolve_id=3 and mispredict_id=5 in the same cycle on a lane with bmask=8'h28 → lane killed. A lane with bmask=8'h08 emerges with bmask_o=8'h00.
- flush_i and stall_i together with 6 valid slots → all valids 0 the next cycle and occ_o=0. With ISSRR_PERF_CNT_EN, perf_squashed_o increases by 6.
- Reset asserted mid-stream with all stages full → next cycle valid_o=0, packet_o=0, occ_o=0; traffic resumes normally after reset deasserts.
